conf_int_mul_share_arb: RTL

//  Round-robin arbiter/sequencer sharing one configurable multiplier (accurate/approx, acc__sel) among NUM_REQ requesters.
//  Per-request precision wish is policed by an accurate-op budget per cycle window; excess accurate requests run approximate.

---
 rtl/conf_int_mul_share_arb_if.sv | 32 +++
 rtl/conf_int_mul_share_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/conf_int_mul_share_arb_if.sv
// Bundles the requester, multiplier and response signals of the shared-multiplier arbiter.
// The slave side is the arbiter itself; the master side is its environment.
interface conf_int_mul_share_arb_if #(
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned ID_W               = 2,
  parameter int unsigned DATA_PATH_BITWIDTH = 16
);
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]                    req_acc;
  logic [DATA_PATH_BITWIDTH-1:0]         mul_a;
  logic [DATA_PATH_BITWIDTH-1:0]         mul_b;
  logic                                  mul_acc__sel;
  logic [63:0]                           mul_d;
  logic                                  rsp_valid;
  logic                                  rsp_ready;
  logic [63:0]                           rsp_d;
  logic [ID_W-1:0]                       rsp_id;
  logic                                  rsp_downgr;

  modport slave (
    input  req_valid, req_a, req_b, req_acc, mul_d, rsp_ready,
    output req_ready, mul_a, mul_b, mul_acc__sel, rsp_valid, rsp_d, rsp_id, rsp_downgr
  );

  modport master (
    output req_valid, req_a, req_b, req_acc, mul_d, rsp_ready,
    input  req_ready, mul_a, mul_b, mul_acc__sel, rsp_valid, rsp_d, rsp_id, rsp_downgr
  );
endinterface

// File: rtl/conf_int_mul_share_arb.sv
// Round-robin sequencer sharing one accurate/approximate multiplier among NUM_REQ requesters,
// with a per-window budget on accurate operations; one operation in flight at a time.
module conf_int_mul_share_arb #(
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned ID_W               = 2,
  parameter int unsigned DATA_PATH_BITWIDTH = 16,
  parameter int unsigned MUL_LAT            = 1,
  parameter int unsigned WINDOW             = 64,
  parameter int unsigned ACC_BUDGET         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  conf_int_mul_share_arb_if.slave   bus
);

  localparam int unsigned DW    = DATA_PATH_BITWIDTH;
  localparam int unsigned LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ACC_W = (ACC_BUDGET > 0) ? $clog2(ACC_BUDGET + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic             grant;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_done;
  logic [WIN_W-1:0] win_cnt;
  logic             win_wrap;
  logic [ACC_W-1:0] acc_used;
  logic [ACC_W-1:0] acc_base;
  logic             want_acc;
  logic             acc_ok;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin : scan
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && bus.req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign grant    = (state == IDLE) && gnt_any;
  assign lat_done = (lat_cnt == LAT_W'(MUL_LAT - 1));
  assign win_wrap = (win_cnt == WIN_W'(WINDOW - 1));

  // A grant on the wrap edge is judged against the fresh window.
  assign acc_base = win_wrap ? '0 : acc_used;
  assign want_acc = bus.req_acc[gnt_id];
  assign acc_ok   = want_acc && (acc_base < ACC_W'(ACC_BUDGET));

  // Grant is offered combinationally only while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (rst && grant) begin
      bus.req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)         state_nxt = EXEC;
      EXEC:    if (lat_done)      state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr           <= '0;
      lat_cnt          <= '0;
      win_cnt          <= '0;
      acc_used         <= '0;
      bus.mul_a        <= '0;
      bus.mul_b        <= '0;
      bus.mul_acc__sel <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_d        <= '0;
      bus.rsp_id       <= '0;
      bus.rsp_downgr   <= 1'b0;
    end else begin
      win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);

      if (grant) begin
        acc_used <= acc_base + ACC_W'(acc_ok);
      end else begin
        acc_used <= acc_base;
      end

      if (grant) begin
        rr_ptr           <= ID_W'((32'(gnt_id) + 32'd1) % NUM_REQ);
        lat_cnt          <= '0;
        bus.mul_a        <= bus.req_a[32'(gnt_id)*DW +: DW];
        bus.mul_b        <= bus.req_b[32'(gnt_id)*DW +: DW];
        bus.mul_acc__sel <= acc_ok;
        bus.rsp_id       <= gnt_id;
        bus.rsp_downgr   <= want_acc && !acc_ok;
      end

      // Operands are parked at zero outside EXEC so the multiplier sees no toggling.
      if (state == EXEC) begin
        if (lat_done) begin
          bus.rsp_d        <= bus.mul_d;
          bus.rsp_valid    <= 1'b1;
          bus.mul_a        <= '0;
          bus.mul_b        <= '0;
          bus.mul_acc__sel <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
      end

      if ((state == RESP) && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

endmodule
